// File: rtl/vend_core_param.sv
// Parametrised vending controller: coin credit accumulation, per-product pricing,
// timed vend hold and greedy 25/10/5 change return, advancing only on clk_en ticks.
module vend_core_param #(
  parameter int NUM_PROD = 4,
  parameter int CREDIT_W = 8,
  parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES = {8'd30, 8'd25, 8'd20, 8'd15},
  parameter int MAX_CREDIT = 95,
  parameter int VEND_HOLD = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                clk_en,
  input  logic [2:0]          coin,
  input  logic [NUM_PROD-1:0] sel,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic [NUM_PROD-1:0] vend,
  output logic [2:0]          chg_coin,
  output logic                reject,
  output logic                denied,
  output logic [1:0]          state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CREDIT = 2'd1,
    S_VEND   = 2'd2,
    S_CHANGE = 2'd3
  } state_t;

  localparam int HOLD_W = (VEND_HOLD > 1) ? $clog2(VEND_HOLD) : 1;
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(VEND_HOLD - 1);
  localparam logic [CREDIT_W:0]   MAX_SUM   = (CREDIT_W + 1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] C5        = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] C10       = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] C25       = CREDIT_W'(25);

  state_t                state_reg, state_next;
  logic [CREDIT_W-1:0]   credit_reg, credit_next;
  logic [NUM_PROD-1:0]   vend_reg, vend_next;
  logic [HOLD_W-1:0]     hold_reg, hold_next;
  logic [2:0]            chg_reg, chg_next;
  logic                  reject_reg, reject_next;
  logic                  denied_reg, denied_next;
  logic [2:0]            coin_prev_reg;
  logic [NUM_PROD-1:0]   sel_prev_reg;
  logic                  cancel_prev_reg;

  logic [2:0]            coin_rise;
  logic                  coin_ev, coin_single, coin_fits;
  logic [CREDIT_W-1:0]   coin_val;
  logic [CREDIT_W:0]     coin_sum;
  logic                  sel_ev, sel_single, cancel_ev;
  logic                  accepting, cancel_take, sel_take;
  logic [CREDIT_W-1:0]   price_term [NUM_PROD];
  logic [CREDIT_W-1:0]   price_sel;

  // A multi-hot sel ORs several prices together, but such selections are denied anyway.
  for (genvar gi = 0; gi < NUM_PROD; gi++) begin : g_price
    assign price_term[gi] = sel[gi] ? PRICES[gi*CREDIT_W +: CREDIT_W] : '0;
  end

  always_comb begin
    price_sel = '0;
    for (int i = 0; i < NUM_PROD; i++) price_sel = price_sel | price_term[i];
  end

  assign coin_rise   = coin & ~coin_prev_reg;
  assign coin_ev     = |coin_rise;
  assign coin_single = $onehot(coin_rise);
  assign coin_sum    = {1'b0, credit_reg} + {1'b0, coin_val};
  assign coin_fits   = coin_sum <= MAX_SUM;
  assign sel_ev      = (sel_prev_reg == '0) && (sel != '0);
  assign sel_single  = $onehot(sel);
  assign cancel_ev   = cancel & ~cancel_prev_reg;
  assign accepting   = (state_reg == S_IDLE) || (state_reg == S_CREDIT);
  assign cancel_take = cancel_ev && (state_reg == S_CREDIT);
  assign sel_take    = sel_ev && accepting && !cancel_take;

  always_comb begin
    coin_val = '0;
    case (coin_rise)
      3'b001:  coin_val = C5;
      3'b010:  coin_val = C10;
      3'b100:  coin_val = C25;
      default: coin_val = '0;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    credit_next = credit_reg;
    vend_next   = vend_reg;
    hold_next   = hold_reg;
    chg_next    = 3'b000;
    reject_next = 1'b0;
    denied_next = 1'b0;

    case (state_reg)
      S_IDLE, S_CREDIT: begin
        if (cancel_take) begin
          state_next = S_CHANGE;
        end else if (sel_take) begin
          if (sel_single && (credit_reg >= price_sel)) begin
            credit_next = credit_reg - price_sel;
            vend_next   = sel;
            hold_next   = '0;
            state_next  = S_VEND;
          end else begin
            denied_next = 1'b1;
          end
        end else if (coin_ev && coin_single && coin_fits) begin
          credit_next = coin_sum[CREDIT_W-1:0];
          state_next  = S_CREDIT;
        end
        // Any coin edge not accepted above is refused, including one shadowed by cancel/select.
        reject_next = coin_ev && (cancel_take || sel_take || !coin_single || !coin_fits);
      end
      S_VEND: begin
        reject_next = coin_ev;
        if (hold_reg == HOLD_LAST) begin
          vend_next  = '0;
          state_next = (credit_reg != '0) ? S_CHANGE : S_IDLE;
        end else begin
          hold_next = hold_reg + 1'b1;
        end
      end
      S_CHANGE: begin
        reject_next = coin_ev;
        if (credit_reg == '0) begin
          state_next = S_IDLE;
        end else if (credit_reg >= C25) begin
          chg_next    = 3'b100;
          credit_next = credit_reg - C25;
        end else if (credit_reg >= C10) begin
          chg_next    = 3'b010;
          credit_next = credit_reg - C10;
        end else begin
          chg_next    = 3'b001;
          credit_next = credit_reg - C5;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg       <= S_IDLE;
      credit_reg      <= '0;
      vend_reg        <= '0;
      hold_reg        <= '0;
      chg_reg         <= 3'b000;
      reject_reg      <= 1'b0;
      denied_reg      <= 1'b0;
      coin_prev_reg   <= 3'b000;
      sel_prev_reg    <= '0;
      cancel_prev_reg <= 1'b0;
    end else if (clk_en) begin
      state_reg       <= state_next;
      credit_reg      <= credit_next;
      vend_reg        <= vend_next;
      hold_reg        <= hold_next;
      chg_reg         <= chg_next;
      reject_reg      <= reject_next;
      denied_reg      <= denied_next;
      coin_prev_reg   <= coin;
      sel_prev_reg    <= sel;
      cancel_prev_reg <= cancel;
    end else begin
      // Pulses last exactly the tick cycle that produced them.
      chg_reg    <= 3'b000;
      reject_reg <= 1'b0;
      denied_reg <= 1'b0;
    end
  end

  assign credit   = credit_reg;
  assign vend     = vend_reg;
  assign chg_coin = chg_reg;
  assign reject   = reject_reg;
  assign denied   = denied_reg;
  assign state    = state_reg;

endmodule

// File: tb/tb_vend_core_param.sv
// Scoreboard bench for vend_core_param: directed test-plan scenarios plus random
// stimulus, checked against a cents-level behavioural model of the vending rules.
module tb_vend_core_param;

  localparam int NP   = 4;
  localparam int CW   = 8;
  localparam int MAXC = 95;
  localparam int HOLD = 4;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          clk_en = 1'b0;
  logic [2:0]    coin = '0;
  logic [NP-1:0] sel = '0;
  logic          cancel = 1'b0;
  logic [CW-1:0] credit;
  logic [NP-1:0] vend;
  logic [2:0]    chg_coin;
  logic          reject, denied;
  logic [1:0]    state;

  vend_core_param #(
    .NUM_PROD(NP), .CREDIT_W(CW), .PRICES({8'd30, 8'd25, 8'd20, 8'd15}),
    .MAX_CREDIT(MAXC), .VEND_HOLD(HOLD)
  ) dut (
    .clk(clk), .clr(clr), .clk_en(clk_en), .coin(coin), .sel(sel), .cancel(cancel),
    .credit(credit), .vend(vend), .chg_coin(chg_coin), .reject(reject),
    .denied(denied), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int credit; int vend; int chg; int rej; int den; int st;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_no  = 0;

  // Behavioural model, in cents and plain integers.
  int price [NP] = '{15, 20, 25, 30};
  int m_credit = 0, m_state = 0, m_vend = 0, m_left = 0;
  int m_chg = 0, m_rej = 0, m_den = 0;
  int p_coin = 0, p_sel = 0, p_cancel = 0;

  function automatic int coin_cents(int bits);
    if (bits == 1) return 5;
    if (bits == 2) return 10;
    if (bits == 4) return 25;
    return 0;
  endfunction

  task automatic model_step(input int r, input int en, input int c, input int s, input int k);
    int rise, nrise, sel_event, can_event, accepting, taken, give, idx;
    m_chg = 0; m_rej = 0; m_den = 0;
    if (r != 0) begin
      m_credit = 0; m_state = 0; m_vend = 0; m_left = 0;
      p_coin = 0; p_sel = 0; p_cancel = 0;
      return;
    end
    if (en == 0) return;
    rise      = c & ~p_coin;
    nrise     = $countones(rise[2:0]);
    sel_event = (p_sel == 0 && s != 0);
    can_event = (k != 0 && p_cancel == 0);
    p_coin = c; p_sel = s; p_cancel = k;
    accepting = (m_state == 0 || m_state == 1);
    taken = 0;
    if (accepting) begin
      if (can_event && m_state == 1) begin
        m_state = 3; taken = 1;
      end else if (sel_event) begin
        taken = 1;
        idx = 0;
        for (int i = 0; i < NP; i++) if (s == (1 << i)) idx = i;
        if ($countones(s[NP-1:0]) == 1 && m_credit >= price[idx]) begin
          m_credit -= price[idx]; m_vend = s; m_left = HOLD; m_state = 2;
        end else m_den = 1;
      end
    end else if (m_state == 2) begin
      m_left--;
      if (m_left == 0) begin
        m_vend = 0; m_state = (m_credit > 0) ? 3 : 0;
      end
    end else begin
      if (m_credit == 0) m_state = 0;
      else begin
        give = (m_credit >= 25) ? 25 : (m_credit >= 10) ? 10 : 5;
        m_chg = (give == 25) ? 4 : (give == 10) ? 2 : 1;
        m_credit -= give;
      end
    end
    if (nrise > 0) begin
      if (accepting && !taken && nrise == 1 && m_credit + coin_cents(rise) <= MAXC) begin
        m_credit += coin_cents(rise); m_state = 1;
      end else m_rej = 1;
    end
  endtask

  // One clock cycle: drive, let the edge happen, predict the post-edge outputs.
  task automatic cyc(input int en, input int c, input int s, input int k);
    exp_t e;
    clk_en = en[0]; coin = c[2:0]; sel = s[NP-1:0]; cancel = k[0];
    @(posedge clk);
    model_step(int'(clr), en, c, s, k);
    e.credit = m_credit; e.vend = m_vend; e.chg = m_chg;
    e.rej = m_rej; e.den = m_den; e.st = m_state;
    q.push_back(e);
    #1;
  endtask

  task automatic press_coin(input int c);
    cyc(1, c, 0, 0); cyc(1, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(1, 0, 0, 0);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every clock presents a full output set to be scored.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc_no++;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_tests++;
        if (int'(credit) != e.credit || int'(vend) != e.vend || int'(chg_coin) != e.chg ||
            int'(reject) != e.rej || int'(denied) != e.den || int'(state) != e.st) begin
          n_fail++;
          $display("FAIL scoreboard cyc %0d: got credit=%0d vend=%0d chg=%0d rej=%0d den=%0d st=%0d expected credit=%0d vend=%0d chg=%0d rej=%0d den=%0d st=%0d",
                   cyc_no, credit, vend, chg_coin, reject, denied, state,
                   e.credit, e.vend, e.chg, e.rej, e.den, e.st);
        end else begin
          $display("[TB] cyc %0d ok credit=%0d vend=%0d chg=%0d rej=%0d den=%0d st=%0d",
                   cyc_no, credit, vend, chg_coin, reject, denied, state);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, s, k, en;
    clr = 1'b1;
    cyc(0, 0, 0, 0); cyc(1, 0, 0, 0);
    clr = 1'b0;
    check("reset_credit", int'(credit), 0);
    check("reset_state", int'(state), 0);

    // 5c, premature select denied, then 10c and an exact-price vend.
    press_coin(1);
    cyc(1, 0, 1, 0);
    check("deny_low_credit", int'(denied), 1);
    cyc(1, 0, 0, 0);
    check("credit_after_deny", int'(credit), 5);
    press_coin(2);
    check("credit_15", int'(credit), 15);
    cyc(1, 0, 1, 0);
    check("vend_p0", int'(vend), 1);
    check("credit_after_vend", int'(credit), 0);
    cyc(1, 0, 0, 0); ticks(2);
    check("vend_still_held", int'(vend), 1);
    ticks(1);
    check("vend_released_idle", int'(state), 0);

    // 50c, buy product 2 for 25c, receive one 25c coin.
    press_coin(4); press_coin(4);
    cyc(1, 0, 4, 0);
    check("credit_50_to_25", int'(credit), 25);
    cyc(1, 0, 0, 0); ticks(3);
    check("vend_to_change", int'(state), 3);
    ticks(1);
    check("chg_25", int'(chg_coin), 4);
    ticks(1);
    check("change_done_idle", int'(state), 0);

    // Credit cap.
    press_coin(4); press_coin(4); press_coin(4); press_coin(2);
    cyc(1, 4, 0, 0);
    check("cap_reject", int'(reject), 1);
    check("cap_credit_85", int'(credit), 85);
    cyc(1, 0, 0, 0);
    press_coin(2);
    check("credit_95", int'(credit), 95);
    cyc(1, 0, 0, 1); cyc(1, 0, 0, 0); ticks(6);
    check("refund_95_idle", int'(state), 0);

    // 40c cancel: 25, 10, 5.
    press_coin(4); press_coin(2); press_coin(1);
    cyc(1, 0, 0, 1);
    check("cancel_change", int'(state), 3);
    cyc(1, 0, 0, 0); check("chg_seq_25", int'(chg_coin), 4);
    cyc(1, 0, 0, 0); check("chg_seq_10", int'(chg_coin), 2);
    cyc(1, 0, 0, 0); check("chg_seq_5", int'(chg_coin), 1);
    check("chg_seq_credit0", int'(credit), 0);
    cyc(1, 0, 0, 0); check("chg_seq_idle", int'(state), 0);

    // Multi-hot select and coins, then reset mid-change at 35c.
    press_coin(4); press_coin(4);
    cyc(1, 0, 3, 0);
    check("multihot_sel_denied", int'(denied), 1);
    cyc(1, 3, 0, 0);
    check("multihot_coin_reject", int'(reject), 1);
    check("multihot_credit", int'(credit), 50);
    cyc(1, 0, 0, 0);
    press_coin(2);
    cyc(1, 0, 0, 1); cyc(1, 0, 0, 0);
    check("mid_change_35", int'(credit), 35);
    clr = 1'b1; cyc(0, 0, 0, 0); clr = 1'b0;
    check("clr_credit", int'(credit), 0);
    check("clr_state", int'(state), 0);
    repeat (10) cyc(1, 1, 0, 0);
    check("held_coin_once", int'(credit), 5);

    // Coin during vend.
    press_coin(2);
    cyc(1, 0, 1, 0); cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    check("coin_in_vend_reject", int'(reject), 1);
    cyc(1, 0, 0, 0); ticks(4);

    // Random traffic, including non-tick cycles and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      clr = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      c   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : 0;
      if ($urandom_range(0, 5) == 0)
        s = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 15)) : (1 << $urandom_range(0, 3));
      else s = 0;
      k = ($urandom_range(0, 15) == 0) ? 1 : 0;
      cyc(en, c, s, k);
    end
    clr = 1'b0;

    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
